alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Successor to the single-cycle ALU control decoder, parametrised in datapath width.
- Adds a multi-cycle multiply/divide path with HI/LO result registers and a start/busy/done handshake.
- Sits between the main controller and the datapath ALU:
  - Drives the 3-bit ALU operation combinationally for single-cycle ops.
  - Runs an iterative shift-add multiplier or restoring divider for mult/div, stalling the pipeline via busy.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥ 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- alu_op  in  2  class from main controller: 00 add, 01 sub, 10 R-type (use func), 11 slt.
- func  in  6  R-type function field.
- start  in  1  request; qualified only when alu_op=10 and func is a mult/div code.
- a  in  WIDTH  operand rs.
- b  in  WIDTH  operand rt.
- alu_operation  out  3  combinational op to datapath ALU: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal  out  1  combinational; 1 when alu_op=10 and func is unrecognised.
- busy  out  1  high while an iterative op is in flight.
- done  out  1  one-cycle pulse when HI/LO are updated.
- hi  out  WIDTH  product upper half / remainder.
- lo  out  WIDTH  product lower half / quotient.
- div_by_zero  out  1  sticky until next accepted start; set when a div completes with b=0.

Behaviour:
- Reset: state IDLE, counter 0, busy=0, done=0, hi=0, lo=0, div_by_zero=0. Reset mid-operation aborts; HI/LO are cleared, not partially written.
- Decode is purely combinational and independent of FSM state:
  - alu_op 00 → 010; 01 → 110; 11 → 111.
  - alu_op 10, by func: 100000 → 010; 100010 → 110; 100001 and 100100 → 000; 100101 → 001; 101010 → 111.
  - alu_op 10 with mult/div codes 011000 mult, 011001 multu, 011010 div, 011011 divu → 010, illegal=0.
  - Any other func → 010 with illegal=1. No latch is inferred; every path assigns.
- Accept condition: start=1, state IDLE, alu_op=10, func a mult/div code. Operands a and b and a signed flag are captured on that edge.
- start is ignored while busy=1. It is also ignored with any other func; no state change occurs.
- FSM states:
  - IDLE: on accept → RUN; busy asserts in the next cycle.
  - RUN: one iteration per cycle, WIDTH cycles. After the last iteration → FIX.
  - FIX: sign correction; writes HI/LO; pulses done=1 for exactly one cycle. busy=0 in the same cycle. Next state IDLE.
- Latency: accept at edge 0; done=1 and HI/LO valid in the cycle after edge WIDTH+1. A start in the done cycle is accepted, giving back-to-back operation.
- Signed ops (mult, div) operate on magnitudes; signs are applied in FIX.
  - Product sign = sign(a) xor sign(b).
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
- Multiply: unsigned 2·WIDTH result; hi = upper half, lo = lower half.
- Divide by zero: lo = all ones, hi = a, div_by_zero=1. Signedness is ignored. Latency is unchanged.
- Signed overflow (a = most-negative, b = −1): lo = most-negative, hi = 0, div_by_zero=0.
- HI/LO hold their value between operations and change only in FIX.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op constants: ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111.
  - alu_op class constants.
  - func code constants, including the four mult/div codes.
  - FSM state enum: IDLE, RUN, FIX.
- One sub-module, muldiv_iter, holds the counter, the shift-add/restoring datapath and the sign fix. alu_op_sequencer keeps the decode, the handshake and HI/LO.

Test Plan:
- Decode sweep: all alu_op values × all 64 func codes → alu_operation and illegal match the table; e.g. alu_op=10, func=111111 → 010 with illegal=1.
- WIDTH=32, mult, a=−7, b=6 → busy for 33 cycles, then done pulses once with hi=FFFFFFFF, lo=FFFFFFD6. Same operands with multu → hi=00000005, lo=FFFFFFD6.
- WIDTH=32, div, a=−17, b=5 → lo=FFFFFFFD (−3), hi=FFFFFFFE (−2). divu with a=17, b=5 → lo=3, hi=2.
- divu with a=0x1234, b=0 → lo=FFFFFFFF, hi=00001234, div_by_zero=1. The next accepted start clears the flag.
- Back-to-back and protocol:
  - start held high across a whole operation → exactly one op accepted while busy.
  - New start in the done cycle → accepted; second done arrives exactly WIDTH+2 cycles later.
- Reset: assert rst asynchronously mid-RUN (cycle 10) → busy, done, hi and lo go to 0 immediately with no clock edge. After release, a new mult completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU control sequencer: ALU op codes, controller
// op classes, R-type function codes and the mult/div FSM state encoding.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_SLT   = 2'b11;

   localparam logic [5:0] FUNC_ADD   = 6'b100000;
   localparam logic [5:0] FUNC_ADDU  = 6'b100001;
   localparam logic [5:0] FUNC_SUB   = 6'b100010;
   localparam logic [5:0] FUNC_AND   = 6'b100100;
   localparam logic [5:0] FUNC_OR    = 6'b100101;
   localparam logic [5:0] FUNC_SLT   = 6'b101010;
   localparam logic [5:0] FUNC_MULT  = 6'b011000;
   localparam logic [5:0] FUNC_MULTU = 6'b011001;
   localparam logic [5:0] FUNC_DIV   = 6'b011010;
   localparam logic [5:0] FUNC_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } state_t;

   // The four mult/div codes share the 0110xx prefix.
   function automatic logic is_muldiv(input logic [5:0] f);
      return (f[5:2] == 4'b0110);
   endfunction

   // Within the mult/div group, bit 0 clear selects the signed variant.
   function automatic logic is_signed_op(input logic [5:0] f);
      return ~f[0];
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// with the sign correction and divide-by-zero override applied on the result.
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo,
   output logic             dbz
);

   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   acc_r;
   logic [WIDTH-1:0]   mq_r;
   logic [WIDTH-1:0]   dvs_r;
   logic [WIDTH-1:0]   a_raw_r;
   logic               div_r;
   logic               neg_a_r;
   logic               neg_b_r;
   logic               b_zero_r;

   logic               neg_a_s;
   logic               neg_b_s;
   logic [WIDTH-1:0]   a_mag_s;
   logic [WIDTH-1:0]   b_mag_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH:0]     div_shift_s;
   logic [WIDTH:0]     div_diff_s;
   logic               div_ge_s;
   logic [WIDTH-1:0]   div_rem_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_neg_s;
   logic [WIDTH-1:0]   quo_neg_s;
   logic [WIDTH-1:0]   rem_neg_s;

   assign neg_a_s = is_signed & a[WIDTH-1];
   assign neg_b_s = is_signed & b[WIDTH-1];
   assign a_mag_s = neg_a_s ? ({WIDTH{1'b0}} - a) : a;
   assign b_mag_s = neg_b_s ? ({WIDTH{1'b0}} - b) : b;

   assign mul_sum_s = {1'b0, acc_r} + (mq_r[0] ? {1'b0, dvs_r} : {(WIDTH+1){1'b0}});

   // A trial subtraction that borrows out of the top bit means the divisor did not fit.
   assign div_shift_s = {acc_r, mq_r[WIDTH-1]};
   assign div_diff_s  = div_shift_s - {1'b0, dvs_r};
   assign div_ge_s    = ~div_diff_s[WIDTH];
   assign div_rem_s   = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];

   assign last = step & (cnt_r == CNT_W'(WIDTH - 1));

   // Operand capture on accept, then one multiply or divide iteration per step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r    <= {CNT_W{1'b0}};
         acc_r    <= {WIDTH{1'b0}};
         mq_r     <= {WIDTH{1'b0}};
         dvs_r    <= {WIDTH{1'b0}};
         a_raw_r  <= {WIDTH{1'b0}};
         div_r    <= 1'b0;
         neg_a_r  <= 1'b0;
         neg_b_r  <= 1'b0;
         b_zero_r <= 1'b0;
      end else if (load) begin
         cnt_r    <= {CNT_W{1'b0}};
         acc_r    <= {WIDTH{1'b0}};
         mq_r     <= a_mag_s;
         dvs_r    <= b_mag_s;
         a_raw_r  <= a;
         div_r    <= is_div;
         neg_a_r  <= neg_a_s;
         neg_b_r  <= neg_b_s;
         b_zero_r <= (b == {WIDTH{1'b0}});
      end else if (step) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         if (div_r) begin
            acc_r <= div_rem_s;
            mq_r  <= {mq_r[WIDTH-2:0], div_ge_s};
         end else begin
            acc_r <= mul_sum_s[WIDTH:1];
            mq_r  <= {mul_sum_s[0], mq_r[WIDTH-1:1]};
         end
      end
   end

   assign prod_s     = {acc_r, mq_r};
   assign prod_neg_s = {(2*WIDTH){1'b0}} - prod_s;
   assign quo_neg_s  = {WIDTH{1'b0}} - mq_r;
   assign rem_neg_s  = {WIDTH{1'b0}} - acc_r;

   // Sign correction; a zero divisor overrides everything and ignores signedness.
   always_comb begin
      res_hi = acc_r;
      res_lo = mq_r;
      dbz    = 1'b0;
      if (div_r) begin
         if (b_zero_r) begin
            res_hi = a_raw_r;
            res_lo = {WIDTH{1'b1}};
            dbz    = 1'b1;
         end else begin
            res_lo = (neg_a_r ^ neg_b_r) ? quo_neg_s : mq_r;
            res_hi = neg_a_r ? rem_neg_s : acc_r;
         end
      end else begin
         if (neg_a_r ^ neg_b_r) begin
            {res_hi, res_lo} = prod_neg_s;
         end else begin
            {res_hi, res_lo} = prod_s;
         end
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU control decode plus the start/busy/done handshake and HI/LO registers
// for the iterative multiply/divide unit.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       func,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [2:0]       alu_operation,
   output logic             illegal,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   if (WIDTH < 4) begin : g_width_check
      $error("alu_op_sequencer: WIDTH must be at least 4");
   end

   state_t           state_r;
   state_t           state_nx_s;
   logic             accept_s;
   logic             step_s;
   logic             last_s;
   logic [WIDTH-1:0] res_hi_s;
   logic [WIDTH-1:0] res_lo_s;
   logic             res_dbz_s;
   logic             busy_r;
   logic             done_r;
   logic             dbz_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;

   // Combinational op decode, independent of the mult/div state.
   always_comb begin
      alu_operation = ALU_ADD;
      illegal       = 1'b0;
      case (alu_op)
         ALUOP_ADD: alu_operation = ALU_ADD;
         ALUOP_SUB: alu_operation = ALU_SUB;
         ALUOP_SLT: alu_operation = ALU_SLT;
         ALUOP_RTYPE: begin
            case (func)
               FUNC_ADD:            alu_operation = ALU_ADD;
               FUNC_SUB:            alu_operation = ALU_SUB;
               FUNC_ADDU, FUNC_AND: alu_operation = ALU_AND;
               FUNC_OR:             alu_operation = ALU_OR;
               FUNC_SLT:            alu_operation = ALU_SLT;
               FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU:
                                    alu_operation = ALU_ADD;
               default: begin
                  alu_operation = ALU_ADD;
                  illegal       = 1'b1;
               end
            endcase
         end
         default: alu_operation = ALU_ADD;
      endcase
   end

   assign accept_s = start & (state_r == IDLE) & (alu_op == ALUOP_RTYPE) & is_muldiv(func);
   assign step_s   = (state_r == RUN);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nx_s = RUN;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_nx_s = FIX;
            end else begin
               state_nx_s = RUN;
            end
         end
         FIX:     state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   muldiv_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_muldiv_iter (
      .clk       (clk),
      .rst       (rst),
      .load      (accept_s),
      .step      (step_s),
      .is_div    (func[1]),
      .is_signed (is_signed_op(func)),
      .a         (a),
      .b         (b),
      .last      (last_s),
      .res_hi    (res_hi_s),
      .res_lo    (res_lo_s),
      .dbz       (res_dbz_s)
   );

   // Handshake flags and HI/LO; HI/LO only ever change when leaving FIX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
         hi_r   <= {WIDTH{1'b0}};
         lo_r   <= {WIDTH{1'b0}};
      end else begin
         done_r <= 1'b0;
         if (state_r == FIX) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            dbz_r  <= res_dbz_s;
            hi_r   <= res_hi_s;
            lo_r   <= res_lo_s;
         end else if (accept_s) begin
            busy_r <= 1'b1;
            dbz_r  <= 1'b0;
         end
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign div_by_zero = dbz_r;
   assign hi          = hi_r;
   assign lo          = lo_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a cycle-level reference model built on
// plain integer arithmetic, compared every cycle, plus literal expectations.
module tb_alu_op_sequencer;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   alu_op = 2'b00;
   logic [5:0]   func = 6'b000000;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   alu_operation;
   logic         illegal, busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;

   alu_op_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .alu_op(alu_op), .func(func), .start(start),
      .a(a), .b(b), .alu_operation(alu_operation), .illegal(illegal),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // {illegal, alu_operation} straight from the decode table
   function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
      case (op)
         2'b00: return 4'b0010;
         2'b01: return 4'b0110;
         2'b11: return 4'b0111;
         default: begin
            case (f)
               6'b100000: return 4'b0010;
               6'b100010: return 4'b0110;
               6'b100001: return 4'b0000;
               6'b100100: return 4'b0000;
               6'b100101: return 4'b0001;
               6'b101010: return 4'b0111;
               6'b011000, 6'b011001, 6'b011010, 6'b011011: return 4'b0010;
               default:   return 4'b1010;
            endcase
         end
      endcase
   endfunction

   function automatic logic ref_md(input logic [5:0] f);
      return (f == 6'b011000) || (f == 6'b011001) || (f == 6'b011010) || (f == 6'b011011);
   endfunction

   // {div_by_zero, hi, lo} from integer arithmetic
   function automatic logic [2*W:0] ref_result(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
      longint sa, sb;
      longint unsigned ua, ub;
      logic [63:0] p;
      logic [W-1:0] q, r;
      sa = $signed(x);
      sb = $signed(y);
      ua = x;
      ub = y;
      if (f == 6'b011000) begin
         p = sa * sb;
         return {1'b0, p};
      end else if (f == 6'b011001) begin
         p = ua * ub;
         return {1'b0, p};
      end else if (y == '0) begin
         return {1'b1, x, {W{1'b1}}};
      end else if (f == 6'b011010) begin
         q = W'(sa / sb);
         r = W'(sa % sb);
         return {1'b0, r, q};
      end else begin
         q = W'(ua / ub);
         r = W'(ua % ub);
         return {1'b0, r, q};
      end
   endfunction

   logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
   logic [W-1:0] m_hi = '0, m_lo = '0;
   int           m_cnt = 0;
   logic [2*W:0] m_pend = '0;

   // Reference model: an accepted op keeps busy for W+1 cycles, then results appear with done
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
         m_hi <= '0; m_lo <= '0; m_cnt <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (m_cnt == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_dbz  <= m_pend[2*W];
               m_hi   <= m_pend[2*W-1:W];
               m_lo   <= m_pend[W-1:0];
            end
            m_cnt <= m_cnt - 1;
         end else if (start && alu_op == 2'b10 && ref_md(func)) begin
            m_busy <= 1'b1;
            m_cnt  <= W + 1;
            m_dbz  <= 1'b0;
            m_pend <= ref_result(func, a, b);
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      logic [3:0] d;
      d = ref_decode(alu_op, func);
      chk("alu_operation", alu_operation, d[2:0]);
      chk("illegal", illegal, d[3]);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("div_by_zero", div_by_zero, m_dbz);
   end

   task automatic launch(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
      @(posedge clk); #1;
      alu_op = 2'b10; func = f; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int busy_n);
      logic ok;
      busy_n = 0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (busy) busy_n++;
      end
      chk("done_seen", ok, 1'b1);
   endtask

   task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
      int n;
      launch(f, x, y);
      wait_done(n);
      chk({tag, "_busy_cycles"}, n, W + 1);
      chk({tag, "_hi"}, hi, eh);
      chk({tag, "_lo"}, lo, el);
      chk({tag, "_dbz"}, div_by_zero, ed);
   endtask

   initial begin
      int n, gap, n_done;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_dbz", div_by_zero, 1'b0);
      rst = 1'b0;

      for (int op = 0; op < 4; op++) begin
         for (int f = 0; f < 64; f++) begin
            @(posedge clk); #1;
            alu_op = 2'(op); func = 6'(f);
         end
      end
      @(posedge clk); #1;
      alu_op = 2'b10; func = 6'b111111;
      #1;
      chk("dec_111111_op", alu_operation, 3'b010);
      chk("dec_111111_illegal", illegal, 1'b1);
      func = 6'b100101;
      #1;
      chk("dec_or_op", alu_operation, 3'b001);
      chk("dec_or_illegal", illegal, 1'b0);

      // start with a non-mult/div func, or with the wrong op class, is ignored
      func = 6'b100000; start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      alu_op = 2'b00; func = 6'b011000;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      chk("ignored_start_busy", busy, 1'b0);

      run_op("mult", 6'b011000, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
      run_op("multu", 6'b011001, 32'hFFFFFFF9, 32'd6, 32'h00000005, 32'hFFFFFFD6, 1'b0);
      run_op("div", 6'b011010, 32'hFFFFFFEF, 32'd5, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
      run_op("div_negneg", 6'b011010, 32'hFFFFFFEF, 32'hFFFFFFFB, 32'hFFFFFFFE, 32'h00000003, 1'b0);
      run_op("divu", 6'b011011, 32'd17, 32'd5, 32'd2, 32'd3, 1'b0);
      run_op("div_ovf", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
      run_op("divu_zero", 6'b011011, 32'h1234, 32'h0, 32'h00001234, 32'hFFFFFFFF, 1'b1);
      repeat (3) @(negedge clk);
      chk("dbz_sticky", div_by_zero, 1'b1);
      launch(6'b011000, 32'd3, 32'd4);
      chk("dbz_cleared_on_accept", div_by_zero, 1'b0);
      wait_done(n);
      chk("mult_3x4_lo", lo, 32'd12);
      run_op("div_zero_signed", 6'b011010, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);

      // start held high through a whole op: only one op runs
      @(posedge clk); #1;
      alu_op = 2'b10; func = 6'b011000; a = 32'd3; b = 32'd5; start = 1'b1;
      n_done = 0;
      for (int i = 0; i < 3 * W; i++) begin
         @(negedge clk);
         if (done) begin
            n_done++;
            start = 1'b0;
         end
      end
      chk("held_start_dones", n_done, 1);
      chk("held_start_lo", lo, 32'd15);
      chk("held_start_idle", busy, 1'b0);

      // back-to-back: start in the done cycle is accepted
      launch(6'b011000, 32'd2, 32'd9);
      wait_done(n);
      chk("b2b_first_lo", lo, 32'd18);
      a = 32'd7; b = 32'd8; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      gap = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         gap++;
         if (done) break;
      end
      chk("b2b_gap", gap, W + 2);
      chk("b2b_second_lo", lo, 32'd56);

      // asynchronous reset mid-RUN
      run_op("mult_pre_rst", 6'b011000, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
      launch(6'b011000, 32'd3, 32'd3);
      repeat (9) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_hi", hi, 32'h0);
      chk("arst_lo", lo, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_op("mult_post_rst", 6'b011000, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
